// File: rtl/button_pkg.sv
// Shared definitions for the button event decoder and its timebase.
// Holds the FSM state encoding, default timing constants and a sizing helper.
package button_pkg;

  localparam int DEF_TICK_DIV     = 125000;
  localparam int DEF_LONG_TICKS   = 800;
  localparam int DEF_REPEAT_TICKS = 200;
  localparam int DEF_GAP_TICKS    = 250;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRESSED  = 3'd1,
    HELD     = 3'd2,
    WAIT_GAP = 3'd3,
    SECOND   = 3'd4
  } btn_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/button_event_decoder_tick_gen.sv
// Free-running divider: tick is high for one clk_in cycle out of every TICK_DIV.
// The tick is registered so downstream logic sees a glitch-free strobe.
module tick_gen
  import button_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk_in,
  input  logic rst_n,
  output logic tick
);

  localparam int DW = $clog2(TICK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DIV_PRE  = DW'(TICK_DIV - 2);

  logic [DW-1:0] div_r;
  logic          tick_r;

  // Divider counter and tick strobe, aligned so tick_r is high while div_r is at its last value
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      div_r  <= '0;
      tick_r <= 1'b0;
    end else begin
      if (div_r == DIV_LAST) begin
        div_r <= '0;
      end else begin
        div_r <= div_r + DW'(1);
      end
      tick_r <= (div_r == DIV_PRE);
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/button_event_decoder.sv
// Classifies a debounced button level into short, long, repeat and double-click pulses.
// All durations are counted in ticks of the internal timebase; pulses are registered.
module button_event_decoder
  import button_pkg::*;
#(
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int LONG_TICKS   = DEF_LONG_TICKS,
  parameter int REPEAT_TICKS = DEF_REPEAT_TICKS,
  parameter int GAP_TICKS    = DEF_GAP_TICKS
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic btn_level,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic double_pulse,
  output logic btn_held
);

  localparam int CW = $clog2(max3(LONG_TICKS, REPEAT_TICKS, GAP_TICKS));
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_TICKS - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_TICKS - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_TICKS - 1);

  logic          sync1_r;
  logic          lvl_r;
  logic          tick_s;
  btn_state_e    state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic          short_s, long_s, repeat_s, double_s;
  logic          short_r, long_r, repeat_r, double_r;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .tick   (tick_s)
  );

  // Two-flop synchronizer for the level, which may originate in a divided clock domain
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      lvl_r   <= 1'b0;
    end else begin
      sync1_r <= btn_level;
      lvl_r   <= sync1_r;
    end
  end

  // Next-state and event decode; only tick cycles can move the FSM or the counter
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    short_s  = 1'b0;
    long_s   = 1'b0;
    repeat_s = 1'b0;
    double_s = 1'b0;
    if (tick_s) begin
      case (state_r)
        IDLE: begin
          if (lvl_r) begin
            state_s = PRESSED;
            cnt_s   = '0;
          end else begin
            cnt_s = '0;
          end
        end
        PRESSED: begin
          if (!lvl_r) begin
            state_s = WAIT_GAP;
            cnt_s   = '0;
          end else if (cnt_r == LONG_LAST) begin
            long_s  = 1'b1;
            state_s = HELD;
            cnt_s   = '0;
          end else begin
            cnt_s = cnt_r + CW'(1);
          end
        end
        HELD: begin
          if (!lvl_r) begin
            state_s = IDLE;
            cnt_s   = '0;
          end else if (cnt_r == REP_LAST) begin
            repeat_s = 1'b1;
            cnt_s    = '0;
          end else begin
            cnt_s = cnt_r + CW'(1);
          end
        end
        WAIT_GAP: begin
          if (lvl_r) begin
            state_s = SECOND;
            cnt_s   = '0;
          end else if (cnt_r == GAP_LAST) begin
            short_s = 1'b1;
            state_s = IDLE;
            cnt_s   = '0;
          end else begin
            cnt_s = cnt_r + CW'(1);
          end
        end
        // The second press is never timed, so the counter simply holds
        SECOND: begin
          if (!lvl_r) begin
            double_s = 1'b1;
            state_s  = IDLE;
            cnt_s    = '0;
          end else begin
            cnt_s = cnt_r;
          end
        end
        default: begin
          state_s = IDLE;
          cnt_s   = '0;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // State, counter and registered event pulses
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      cnt_r    <= '0;
      short_r  <= 1'b0;
      long_r   <= 1'b0;
      repeat_r <= 1'b0;
      double_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      short_r  <= short_s;
      long_r   <= long_s;
      repeat_r <= repeat_s;
      double_r <= double_s;
    end
  end

  assign short_pulse  = short_r;
  assign long_pulse   = long_r;
  assign repeat_pulse = repeat_r;
  assign double_pulse = double_r;
  assign btn_held     = lvl_r;

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder with a tick-level reference model.
// The model is compared against every output on every clock cycle.
module tb_button_event_decoder;

  localparam int TD = 4;
  localparam int LT = 8;
  localparam int RT = 4;
  localparam int GT = 5;

  logic clk_in = 1'b0;
  logic rst_n = 1'b0;
  logic btn_level = 1'b0;
  logic short_pulse, long_pulse, repeat_pulse, double_pulse, btn_held;

  button_event_decoder #(
    .TICK_DIV(TD), .LONG_TICKS(LT), .REPEAT_TICKS(RT), .GAP_TICKS(GT)
  ) dut (
    .clk_in       (clk_in),
    .rst_n        (rst_n),
    .btn_level    (btn_level),
    .short_pulse  (short_pulse),
    .long_pulse   (long_pulse),
    .repeat_pulse (repeat_pulse),
    .double_pulse (double_pulse),
    .btn_held     (btn_held)
  );

  always #5 clk_in = ~clk_in;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
  endtask

  // Model state: edges since reset, synchronizer image, and a phase with run lengths
  int e_cnt = 0;
  bit m_s1 = 1'b0, m_s2 = 1'b0;
  int phase = 0;  // 0 idle, 1 pressing, 2 released gap, 3 second press
  int run = 0;
  int gap = 0;
  bit x_short, x_long, x_rep, x_dbl;

  int n_short = 0, n_long = 0, n_rep = 0, n_dbl = 0;
  int long_at = -1, rep1_at = -1;

  always begin
    @(posedge clk_in);
    #1;
    x_short = 1'b0; x_long = 1'b0; x_rep = 1'b0; x_dbl = 1'b0;
    if (!rst_n) begin
      e_cnt = 0; m_s1 = 1'b0; m_s2 = 1'b0; phase = 0; run = 0; gap = 0;
    end else begin
      e_cnt++;
      if (e_cnt % TD == 0) begin
        case (phase)
          0: if (m_s2) begin phase = 1; run = 0; end
          1: begin
            if (m_s2) begin
              run++;
              if (run == LT) x_long = 1'b1;
              else if (run > LT && (run - LT) % RT == 0) x_rep = 1'b1;
            end else if (run >= LT) phase = 0;
            else begin phase = 2; gap = 0; end
          end
          2: begin
            if (m_s2) phase = 3;
            else begin
              gap++;
              if (gap == GT) begin x_short = 1'b1; phase = 0; end
            end
          end
          default: if (!m_s2) begin x_dbl = 1'b1; phase = 0; end
        endcase
      end
      m_s2 = m_s1;
      m_s1 = btn_level;
    end
    check("short_pulse", short_pulse, x_short);
    check("long_pulse", long_pulse, x_long);
    check("repeat_pulse", repeat_pulse, x_rep);
    check("double_pulse", double_pulse, x_dbl);
    check("btn_held", btn_held, m_s2);
    if (short_pulse) n_short++;
    if (double_pulse) n_dbl++;
    if (long_pulse) begin n_long++; long_at = e_cnt; end
    if (repeat_pulse) begin
      n_rep++;
      if (rep1_at < 0) rep1_at = e_cnt;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_in);
    #2;
  endtask

  task automatic hold(input bit v, input int ticks);
    btn_level = v;
    cyc(ticks * TD);
  endtask

  task automatic clear_counts();
    n_short = 0; n_long = 0; n_rep = 0; n_dbl = 0;
    long_at = -1; rep1_at = -1;
  endtask

  task automatic expect_counts(input string tag, input int s, input int l, input int r, input int d);
    check({tag, "_short_cnt"}, n_short, s);
    check({tag, "_long_cnt"}, n_long, l);
    check({tag, "_repeat_cnt"}, n_rep, r);
    check({tag, "_double_cnt"}, n_dbl, d);
  endtask

  initial begin
    cyc(3);
    check("reset_short", short_pulse, 1'b0);
    check("reset_held", btn_held, 1'b0);
    rst_n = 1'b1;
    cyc(8);

    // Short press: 3 ticks high, then a long idle
    clear_counts();
    hold(1'b1, 3); hold(1'b0, 10);
    expect_counts("s1", 1, 0, 0, 0);

    // Long hold with auto-repeat; release must stay silent
    clear_counts();
    hold(1'b1, 21); hold(1'b0, 10);
    expect_counts("s2", 0, 1, 3, 0);
    check("s2_repeat_spacing", rep1_at - long_at, RT * TD);

    // Double click with a short gap
    clear_counts();
    hold(1'b1, 2); hold(1'b0, 2); hold(1'b1, 2); hold(1'b0, 10);
    expect_counts("s3", 0, 0, 0, 1);

    // Gap just inside the window
    clear_counts();
    hold(1'b1, 2); hold(1'b0, 5); hold(1'b1, 2); hold(1'b0, 10);
    expect_counts("s4a", 0, 0, 0, 1);

    // Gap reaching the limit: short, then the next press is a fresh single press
    clear_counts();
    hold(1'b1, 2); hold(1'b0, 6); hold(1'b1, 2); hold(1'b0, 10);
    expect_counts("s4b", 2, 0, 0, 0);

    // Two-cycle blip that never coincides with a tick
    clear_counts();
    for (int i = 0; i < 2 * TD && (e_cnt % TD) != 2; i++) cyc(1);
    check("s5_align", e_cnt % TD, 2);
    btn_level = 1'b1;
    cyc(2);
    btn_level = 1'b0;
    cyc(10 * TD);
    expect_counts("s5", 0, 0, 0, 0);

    // Reset in the middle of a press, released with the button up
    clear_counts();
    btn_level = 1'b1;
    cyc(6 * TD);
    check("s6_held_before", btn_held, 1'b1);
    rst_n = 1'b0;
    #1;
    check("s6_async_held", btn_held, 1'b0);
    check("s6_async_any", {short_pulse, long_pulse, repeat_pulse, double_pulse}, 4'b0000);
    btn_level = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(20 * TD);
    expect_counts("s6", 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
